// File: rtl/fpadd_result_reader.sv
`default_nettype none
// ============================================================================
// fpadd_result_reader : launches operands to the FP adder, samples the packed
// Result after a fixed settle time and returns it decoded with its tag.
// Revision: 1.0
// ============================================================================
module fpadd_result_reader #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      bus_a,
    output logic [31:0]      bus_b,
    input  logic [31:0]      bus_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sign,
    output logic [7:0]       out_exp,
    output logic [22:0]      out_mant,
    output logic             out_is_nan,
    output logic             out_is_inf,
    output logic             out_is_zero,
    output logic             out_is_sub,
    output logic             busy
);

    localparam int CW = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] C_CNT_INIT = CW'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("fpadd_result_reader: SETTLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_bus_a;
    logic [31:0]        r_bus_b;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_result;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_valid;
    logic               r_is_nan;
    logic               r_is_inf;
    logic               r_is_zero;
    logic               r_is_sub;

    logic               w_ready;
    logic               w_accept;
    logic               w_capture;
    logic               w_release;
    logic               w_exp_max;
    logic               w_exp_min;
    logic               w_mant_nz;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    w_ready     = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = in_valid ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && w_ready;

    // Classification of the live adder output; registered only on capture.
    assign w_exp_max = (bus_result[30:23] == 8'hFF);
    assign w_exp_min = (bus_result[30:23] == 8'h00);
    assign w_mant_nz = (bus_result[22:0] != 23'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bus_a     <= '0;
            r_bus_b     <= '0;
            r_tag       <= '0;
            r_result    <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_is_nan    <= 1'b0;
            r_is_inf    <= 1'b0;
            r_is_zero   <= 1'b0;
            r_is_sub    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bus_a <= in_a;
                r_bus_b <= in_b;
                r_tag   <= in_tag;
                r_cnt   <= C_CNT_INIT;
            end else if (r_state == ST_SETTLE && !w_capture) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_capture) begin
                r_result    <= bus_result;
                r_out_tag   <= r_tag;
                r_out_valid <= 1'b1;
                r_is_nan    <= w_exp_max && w_mant_nz;
                r_is_inf    <= w_exp_max && !w_mant_nz;
                r_is_zero   <= w_exp_min && !w_mant_nz;
                r_is_sub    <= w_exp_min && w_mant_nz;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_ready;
    assign bus_a       = r_bus_a;
    assign bus_b       = r_bus_b;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_tag     = r_out_tag;
    assign out_sign    = r_result[31];
    assign out_exp     = r_result[30:23];
    assign out_mant    = r_result[22:0];
    assign out_is_nan  = r_is_nan;
    assign out_is_inf  = r_is_inf;
    assign out_is_zero = r_is_zero;
    assign out_is_sub  = r_is_sub;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpadd_result_reader.sv
`default_nettype none
// ============================================================================
// tb_fpadd_result_reader : directed bench for two instances (settle 1 and 3)
// checked every cycle against a transaction-level model. Revision: 1.0
// ============================================================================
module tb_fpadd_result_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2];
    logic        ir[2];
    logic [31:0] ia[2];
    logic [31:0] ib[2];
    logic [3:0]  it[2];
    logic [31:0] ba[2];
    logic [31:0] bb[2];
    logic [31:0] br[2];
    logic        ov[2];
    logic        ordy[2];
    logic [31:0] ores[2];
    logic [3:0]  otag[2];
    logic        osign[2];
    logic [7:0]  oexp[2];
    logic [22:0] omant[2];
    logic        onan[2];
    logic        oinf[2];
    logic        ozero[2];
    logic        osub[2];
    logic        obusy[2];

    always #5 clk = ~clk;

    fpadd_result_reader #(.SETTLE_CYCLES(1), .TAG_W(4)) u_s1 (
        .clk(clk), .reset(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]), .in_tag(it[0]),
        .bus_a(ba[0]), .bus_b(bb[0]), .bus_result(br[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_result(ores[0]), .out_tag(otag[0]),
        .out_sign(osign[0]), .out_exp(oexp[0]), .out_mant(omant[0]),
        .out_is_nan(onan[0]), .out_is_inf(oinf[0]), .out_is_zero(ozero[0]),
        .out_is_sub(osub[0]), .busy(obusy[0])
    );

    fpadd_result_reader #(.SETTLE_CYCLES(3), .TAG_W(4)) u_s3 (
        .clk(clk), .reset(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]), .in_tag(it[1]),
        .bus_a(ba[1]), .bus_b(bb[1]), .bus_result(br[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_result(ores[1]), .out_tag(otag[1]),
        .out_sign(osign[1]), .out_exp(oexp[1]), .out_mant(omant[1]),
        .out_is_nan(onan[1]), .out_is_inf(oinf[1]), .out_is_zero(ozero[1]),
        .out_is_sub(osub[1]), .busy(obusy[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // {nan, inf, zero, sub} from the IEEE-754 single field rules.
    function automatic logic [3:0] classify(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'd255) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 8'd0)   return (m != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Transaction model: a request accepted on edge c is answered with the
    // adder value present on edge c+SETTLE, and held until consumed.
    bit          m_pend[2];
    bit          m_val[2];
    int          m_due[2];
    logic [31:0] m_a[2];
    logic [31:0] m_b[2];
    logic [3:0]  m_ptag[2];
    logic [3:0]  m_otag[2];
    logic [31:0] m_res[2];
    logic [3:0]  m_flags[2];

    always @(posedge clk) begin : model
        bit rdy;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k]  = 0;
                m_val[k]   = 0;
                m_a[k]     = '0;
                m_b[k]     = '0;
                m_ptag[k]  = '0;
                m_otag[k]  = '0;
                m_res[k]   = '0;
                m_flags[k] = '0;
            end else begin
                rdy = !m_pend[k] && (!m_val[k] || ordy[k]);
                if (m_val[k] && ordy[k]) m_val[k] = 0;
                if (m_pend[k] && cyc == m_due[k]) begin
                    m_pend[k]  = 0;
                    m_val[k]   = 1;
                    m_res[k]   = br[k];
                    m_flags[k] = classify(br[k]);
                    m_otag[k]  = m_ptag[k];
                end
                if (iv[k] && rdy) begin
                    m_pend[k] = 1;
                    m_due[k]  = cyc + settle_of(k);
                    m_a[k]    = ia[k];
                    m_b[k]    = ib[k];
                    m_ptag[k] = it[k];
                end
            end
        end
        cyc++;
    end

    int          ov3_cnt = 0;
    logic [3:0]  resp_tag3[$];
    int          resp_cyc3[$];

    always @(negedge clk) begin : compare
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d_in_ready", k), ir[k], !m_pend[k] && (!m_val[k] || ordy[k]));
                chk($sformatf("u%0d_busy", k), obusy[k], m_pend[k] || m_val[k]);
                chk($sformatf("u%0d_out_valid", k), ov[k], m_val[k]);
                chk($sformatf("u%0d_bus_a", k), ba[k], m_a[k]);
                chk($sformatf("u%0d_bus_b", k), bb[k], m_b[k]);
                chk($sformatf("u%0d_out_result", k), ores[k], m_res[k]);
                chk($sformatf("u%0d_out_tag", k), otag[k], m_otag[k]);
                chk($sformatf("u%0d_fields", k), {osign[k], oexp[k], omant[k]}, m_res[k]);
                chk($sformatf("u%0d_flags", k), {onan[k], oinf[k], ozero[k], osub[k]}, m_flags[k]);
            end
            if (ov[1]) begin
                ov3_cnt++;
                resp_tag3.push_back(otag[1]);
                resp_cyc3.push_back(cyc);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // Raise a request now (caller is just after a rising edge) and hold it
    // until the edge that accepts it; returns 2 time units after that edge.
    task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        it[k] = tag;
        n = 0;
        @(negedge clk);
        while (!ir[k] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!ir[k]) timeout($sformatf("u%0d_accept", k));
        @(posedge clk);
        #2;
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!ov[k] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!ov[k]) timeout($sformatf("u%0d_response", k));
    endtask

    logic [31:0] cls_val[4]  = '{32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, 32'h0000_0001};
    logic [3:0]  cls_flag[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic        cls_sign[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          acc3[3];

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; ia[k] = '0; ib[k] = '0; it[k] = '0; br[k] = '0; ordy[k] = 0;
        end
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", ir[0], 1);
        chk("reset_out_valid", ov[0], 0);
        chk("reset_bus_a", ba[0], 0);
        chk("reset_out_result", ores[1], 0);
        chk("reset_flags", {onan[0], oinf[0], ozero[0], osub[0]}, 0);
        sync();
        rst = 1'b0;

        // Basic add, settle 1, response held while out_ready is low.
        br[0] = 32'h4040_0000;
        send(0, 32'h3F80_0000, 32'h4000_0000, 4'd3);
        @(negedge clk);
        chk("t1_not_yet_valid", ov[0], 0);
        @(negedge clk);
        chk("t1_valid", ov[0], 1);
        chk("t1_result", ores[0], 32'h4040_0000);
        chk("t1_sign", osign[0], 0);
        chk("t1_exp", oexp[0], 8'h80);
        chk("t1_mant", omant[0], 23'h40_0000);
        chk("t1_flags", {onan[0], oinf[0], ozero[0], osub[0]}, 4'b0000);
        chk("t1_tag", otag[0], 4'd3);
        sync();
        iv[0] = 1'b1; ia[0] = 32'h4110_0000; ib[0] = 32'h3F00_0000; it[0] = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", ir[0], 0);
            chk("hold_valid", ov[0], 1);
            chk("hold_tag", otag[0], 4'd3);
            chk("hold_result", ores[0], 32'h4040_0000);
            chk("hold_bus_a", ba[0], 32'h3F80_0000);
        end
        sync();
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("release_in_ready", ir[0], 1);
        chk("release_busy", obusy[0], 1);
        sync();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("b2b_busy", obusy[0], 1);
        chk("b2b_valid_low", ov[0], 0);
        chk("b2b_bus_a", ba[0], 32'h4110_0000);
        wait_valid(0);
        chk("b2b_tag", otag[0], 4'd5);

        // Class flags, one per special encoding.
        for (int i = 0; i < 4; i++) begin
            sync();
            br[0] = cls_val[i];
            send(0, 32'h1000_0000 + i, 32'h2000_0000 + i, 4'(8 + i));
            wait_valid(0);
            chk($sformatf("cls%0d_flags", i), {onan[0], oinf[0], ozero[0], osub[0]}, cls_flag[i]);
            chk($sformatf("cls%0d_sign", i), osign[0], cls_sign[i]);
            chk($sformatf("cls%0d_result", i), ores[0], cls_val[i]);
        end

        // Settle 3: three back-to-back requests.
        sync();
        ordy[1] = 1'b1;
        br[1] = 32'h4120_0000;
        resp_tag3.delete();
        resp_cyc3.delete();
        for (int t = 1; t <= 3; t++) begin
            send(1, 32'h4000_0000 + t, 32'h3000_0000 + t, 4'(t));
            acc3[t-1] = cyc;
        end
        begin
            int n;
            n = 0;
            while (resp_tag3.size() < 3 && n < 30) begin
                n++;
                @(negedge clk);
            end
        end
        if (resp_tag3.size() < 3) begin
            timeout("s3_responses");
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("s3_tag%0d", i), resp_tag3[i], 4'(i + 1));
                chk($sformatf("s3_latency%0d", i), resp_cyc3[i] - acc3[i], 3);
            end
            chk("s3_spacing01", acc3[1] - acc3[0], 4);
            chk("s3_spacing12", acc3[2] - acc3[1], 4);
        end

        // Only the adder value present on the capture edge is taken.
        sync();
        send(1, 32'h1234_5678, 32'h8765_4321, 4'd9);
        br[1] = 32'h1111_1111;
        sync();
        br[1] = 32'h2222_2222;
        sync();
        br[1] = 32'h3333_3333;
        sync();
        br[1] = 32'h4444_4444;
        wait_valid(1);
        chk("settle_sample", ores[1], 32'h3333_3333);
        chk("settle_tag", otag[1], 4'd9);

        // Reset in the middle of a settle discards the request.
        sync();
        send(1, 32'hAAAA_0000, 32'h5555_0000, 4'd7);
        sync();
        rst = 1'b1;
        sync();
        @(negedge clk);
        chk("mid_rst_valid", ov[1], 0);
        chk("mid_rst_bus_a", ba[1], 0);
        chk("mid_rst_bus_b", bb[1], 0);
        chk("mid_rst_in_ready", ir[1], 1);
        chk("mid_rst_busy", obusy[1], 0);
        begin
            int seen;
            seen = ov3_cnt;
            sync();
            rst = 1'b0;
            repeat (8) @(negedge clk);
            chk("mid_rst_no_response", ov3_cnt, seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpadd_result_reader.md
Name: fpadd_result_reader

Overview:
Sequential front/back end for the combinational FP adder datapath. Accepts operand pairs over a valid/ready stream and drives them onto the adder's A/B inputs. Waits a fixed settle time, then samples the packed Result. It decodes that Result back into sign/exponent/mantissa plus IEEE-754 class flags, making it the reader/unpacker for the pack stage's output. The decoded result is returned over a valid/ready stream with the request's tag.

Parameters:
SETTLE_CYCLES, 1, cycles from operand launch to Result sample; must be >= 1 (elaboration error if 0)
TAG_W, 4, width of the request tag carried through

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_a  input  32  operand A (IEEE-754 single)
in_b  input  32  operand B
in_tag  input  TAG_W  request tag
bus_a  output  32  registered operand A to adder
bus_b  output  32  registered operand B to adder
bus_result  input  32  packed Result from adder
out_valid  output  1  response valid
out_ready  input  1  response consumed when out_valid && out_ready
out_result  output  32  captured Result
out_tag  output  TAG_W  tag of the request
out_sign  output  1  out_result[31]
out_exp  output  8  out_result[30:23]
out_mant  output  23  out_result[22:0]
out_is_nan  output  1  exp==8'hFF && mant!=0
out_is_inf  output  1  exp==8'hFF && mant==0
out_is_zero  output  1  exp==0 && mant==0
out_is_sub  output  1  exp==0 && mant!=0
busy  output  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high: reset sampled high on a clk edge forces state IDLE; in_ready=1; out_valid=0; bus_a/bus_b/out_result/out_tag=0; all flags=0; counter=0.
- Reset has priority over every other event, including mid-SETTLE or mid-RESP. Any in-flight operation is discarded with no response.
- FSM states IDLE, SETTLE, RESP.
- in_ready = (state==IDLE) || (state==RESP && out_ready). Combinational, no in_valid dependency.
- Accept (in_valid && in_ready at edge): latch in_a->bus_a, in_b->bus_b, in_tag->tag reg; cnt <= SETTLE_CYCLES-1; state -> SETTLE.
- SETTLE: if cnt==0, capture bus_result into out_result, tag->out_tag, decode flags, out_valid<=1, state -> RESP; else cnt<=cnt-1.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- RESP: all out_* held stable while out_ready=0. On out_ready=1:
  - with a simultaneous accept: out_valid<=0, new operands launched, state -> SETTLE (back-to-back);
  - without one: out_valid<=0, state -> IDLE.
- Throughput: one operation per SETTLE_CYCLES+1 cycles under continuous in_valid/out_ready.
- bus_a/bus_b hold their last launched values after completion; they are never cleared except by reset.
- Decode fields are registered together with out_result. Class flags are mutually exclusive; a normal number has all four flags 0.
- in_valid while in_ready=0: ignored, no capture; the requester must hold its request.
- Counter width is $clog2(SETTLE_CYCLES)+1 so there is no wrap.

Test Plan:
- SETTLE_CYCLES=1, in_a=3F800000, in_b=40000000, tag=3, bus_result model=40400000 -> out_valid 1 edge after accept; out_result=40400000, sign=0, exp=80, mant=400000, all flags 0, out_tag=3.
- bus_result=7FC00000 -> is_nan=1. 7F800000 -> is_inf=1. 80000000 -> sign=1, is_zero=1. 00000001 -> is_sub=1. Exactly one flag set in each case.
- out_ready held low 5 cycles in RESP -> out_* and out_tag stable; in_ready=0; a new in_valid is not accepted. Release -> accept same cycle, busy stays 1.
- SETTLE_CYCLES=3, tags 1,2,3 issued back-to-back with out_ready=1 -> responses in order 1,2,3, each 3 edges after its accept, one per 4 cycles.
- reset asserted during SETTLE (cnt=1) -> next edge: state IDLE, out_valid=0, bus_a=bus_b=0, in_ready=1; the discarded request never produces a response.
- bus_result changes during SETTLE before the final cycle -> only the value present at the cnt==0 edge appears on out_result.
